// File: rtl/tt_um_alu_host_seq.sv
`default_nettype none
// ============================================================================
// Module  : tt_um_alu_host_seq
// Brief   : Host-side sequencer for an 8-bit ALU. Operands and opcode are
//           delivered one at a time on shared pins under an asynchronous
//           strobe. A single EXEC cycle computes the result, and the result
//           and flags are held for readback.
// Revision: 1.0 - initial release
// ============================================================================
module tt_um_alu_host_seq #(
    parameter int SYNC_STAGES = 2                // legal 2..3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_CMD_LOAD_A = 2'b00;
    localparam logic [1:0] c_CMD_LOAD_B = 2'b01;
    localparam logic [1:0] c_CMD_START  = 2'b10;
    localparam logic [1:0] c_CMD_CLEAR  = 2'b11;

    // Strobe synchronizer and edge detector
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_pulse;
    logic                   w_stb;

    // Captured operands and sequencer state
    state_t     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic       r_sh;
    logic       r_a_vld;
    logic       r_b_vld;
    logic       r_err;
    logic       r_done;
    logic [7:0] r_y;
    logic       r_c;
    logic       r_z;
    logic       r_n;
    logic       r_v;

    // ALU datapath
    logic       w_sub;
    logic [7:0] w_src;
    logic [7:0] w_b_eff;
    logic [8:0] w_sum;
    logic [7:0] w_y;
    logic       w_c;
    logic       w_v;
    logic [1:0] w_cmd;
    logic       w_unused;

    assign w_cmd    = uio_in[2:1];
    assign w_unused = &{uio_in[7:3], ui_in[7:4]};

    // The edge detector keeps tracking while ena is low, so re-enabling never
    // produces a late pulse for a strobe that arrived while disabled.
    assign w_stb = r_pulse & ena;

    // Synchronize the asynchronous strobe and turn its rising edge into a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_last  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], uio_in[0]};
            r_last  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_last;
        end
    end

    // One shared adder serves ADD and SUB (SUB adds ~B with carry-in of 1)
    assign w_sub   = (r_op == 3'b100);
    assign w_src   = r_sh ? r_a : r_b;
    assign w_b_eff = w_sub ? ~r_b : r_b;
    assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {8'd0, w_sub};

    // Opcode decode: result, carry and overflow for the captured operation
    always_comb begin
        w_y = w_src;
        w_c = 1'b0;
        w_v = 1'b0;
        case (r_op)
            3'b000, 3'b100: begin
                w_y = w_sum[7:0];
                w_c = w_sum[8];
                w_v = ~(r_a[7] ^ w_b_eff[7]) & (r_a[7] ^ w_sum[7]);
            end
            3'b010: w_y = r_a & r_b;
            3'b110: w_y = r_a | r_b;
            3'b001: begin
                w_y = {1'b0, w_src[7:1]};
                w_c = w_src[0];
            end
            3'b101: begin
                w_y = {w_src[6:0], 1'b0};
                w_c = w_src[7];
            end
            3'b011: begin
                w_y = {w_src[7], w_src[7:1]};
                w_c = w_src[0];
            end
            default: w_y = w_src;
        endcase
    end

    // Command sequencer: capture operands, run one EXEC cycle, hold results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_op    <= 3'd0;
            r_sh    <= 1'b0;
            r_a_vld <= 1'b0;
            r_b_vld <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= 8'd0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                ST_EXEC: begin
                    r_y     <= w_y;
                    r_c     <= w_c;
                    r_z     <= (w_y == 8'd0);
                    r_n     <= w_y[7];
                    r_v     <= w_v;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                    // Any command landing here, CLEAR included, is dropped
                    if (w_stb) begin
                        r_err <= 1'b1;
                    end
                end
                ST_WAIT, ST_DONE: begin
                    if (w_stb) begin
                        case (w_cmd)
                            c_CMD_LOAD_A: begin
                                r_a     <= ui_in;
                                r_a_vld <= 1'b1;
                                r_done  <= 1'b0;
                            end
                            c_CMD_LOAD_B: begin
                                r_b     <= ui_in;
                                r_b_vld <= 1'b1;
                                r_done  <= 1'b0;
                            end
                            c_CMD_START: begin
                                if (r_a_vld && r_b_vld) begin
                                    r_op    <= ui_in[2:0];
                                    r_sh    <= ui_in[3];
                                    r_done  <= 1'b0;
                                    r_state <= ST_EXEC;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            c_CMD_CLEAR: begin
                                r_a_vld <= 1'b0;
                                r_b_vld <= 1'b0;
                                r_err   <= 1'b0;
                                r_done  <= 1'b0;
                                r_y     <= 8'd0;
                                r_c     <= 1'b0;
                                r_z     <= 1'b0;
                                r_n     <= 1'b0;
                                r_v     <= 1'b0;
                                r_state <= ST_WAIT;
                            end
                            default: r_state <= r_state;
                        endcase
                    end
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign uo_out  = r_y;
    assign uio_out = {r_c, r_z, r_n, r_v, r_done, 3'b000};
    assign uio_oe  = 8'hF8;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_alu_host_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_tt_um_alu_host_seq
// Brief   : Self-checking bench for tt_um_alu_host_seq. Table-driven ALU
//           vectors with a result scoreboard, plus hand sequences for reset,
//           missing operand, EXEC collision, ena gating and strobe timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tt_um_alu_host_seq;

    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] c_LOAD_A = 2'b00;
    localparam logic [1:0] c_LOAD_B = 2'b01;
    localparam logic [1:0] c_START  = 2'b10;
    localparam logic [1:0] c_CLEAR  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic       strb = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign uio_in = {5'b00000, cmd, strb};

    tt_um_alu_host_seq #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // flags ordered {C, Z, N, V}
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       sh;
        logic [7:0] y;
        logic [3:0] f;
    } vec_t;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] f;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Cycle bookkeeping sampled just after each rising edge
    int   cyc = 0;
    int   stb_seen = 0;
    int   stb_cyc = 0;
    int   done_cyc = 0;
    logic done_q = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (dut.w_stb) begin
            stb_seen = stb_seen + 1;
            stb_cyc  = cyc;
        end
        if (uio_out[3] && !done_q) done_cyc = cyc;
        done_q = uio_out[3];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp = n_cmp + 1;
        if (act !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Data/cmd set one clock before the rise and held well past sampling
    task automatic strobe(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd   = c;
        ui_in = d;
        @(negedge clk);
        strb = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        strb = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_result(input string name, input bit chk_lat);
        exp_t e;
        int   t;
        t = 0;
        while (!uio_out[3] && t < 20) begin
            @(negedge clk);
            t = t + 1;
        end
        if (exp_q.size() == 0) begin
            fail_now({name, " scoreboard empty"});
        end else begin
            e = exp_q.pop_front();
            if (t >= 20) fail_now({name, " done"});
            chk({name, " result"}, {uo_out, uio_out}, {e.y, e.f, 1'b1, 3'b000});
            if (chk_lat) chk({name, " latency"}, 16'(done_cyc - stb_cyc), 16'd2);
        end
    endtask

    task automatic wait_exec(input string name, output bit ok);
        int t;
        t = 0;
        while (dut.r_state != 2'd1 && t < 40) begin
            @(negedge clk);
            t = t + 1;
        end
        ok = (t < 40);
        if (!ok) fail_now({name, " EXEC"});
    endtask

    vec_t vecs [15];

    initial begin
        int s0;
        int r0;
        bit ok;

        vecs = '{
            '{8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 4'b0011},
            '{8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 4'b1100},
            '{8'h80, 8'h80, 3'b000, 1'b0, 8'h00, 4'b1101},
            '{8'h05, 8'h05, 3'b100, 1'b0, 8'h00, 4'b1100},
            '{8'h00, 8'h01, 3'b100, 1'b0, 8'hFF, 4'b0010},
            '{8'h80, 8'h01, 3'b100, 1'b0, 8'h7F, 4'b1001},
            '{8'hF0, 8'h3C, 3'b010, 1'b0, 8'h30, 4'b0000},
            '{8'h55, 8'hAA, 3'b010, 1'b0, 8'h00, 4'b0100},
            '{8'h0F, 8'hF0, 3'b110, 1'b0, 8'hFF, 4'b0010},
            '{8'h81, 8'h00, 3'b001, 1'b1, 8'h40, 4'b1000},
            '{8'h00, 8'h81, 3'b101, 1'b0, 8'h02, 4'b1000},
            '{8'h81, 8'h00, 3'b011, 1'b1, 8'hC0, 4'b1010},
            '{8'h11, 8'h7E, 3'b011, 1'b0, 8'h3F, 4'b0000},
            '{8'h55, 8'h00, 3'b111, 1'b0, 8'h00, 4'b0100},
            '{8'hA5, 8'h3C, 3'b111, 1'b1, 8'hA5, 4'b0010}
        };

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset uo_out", {8'd0, uo_out}, 16'h0000);
        chk("reset uio_out", {8'd0, uio_out}, 16'h0000);
        chk("reset uio_oe", {8'd0, uio_oe}, 16'h00F8);
        chk("reset vld/err", {13'd0, dut.r_a_vld, dut.r_b_vld, dut.r_err}, 16'h0000);
        chk("reset state", {14'd0, dut.r_state}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Synchronizer timing: one long strobe gives exactly one delayed pulse
        s0 = stb_seen;
        @(negedge clk);
        cmd   = c_LOAD_A;
        ui_in = 8'h3C;
        @(negedge clk);
        strb = 1'b1;
        r0   = cyc;
        repeat (11) @(negedge clk);
        strb = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        chk("sync pulse count", 16'(stb_seen - s0), 16'd1);
        chk("sync pulse delay", 16'(stb_cyc - r0), 16'(SYNC_STAGES + 1));
        chk("sync load_a", {7'd0, dut.r_a_vld, dut.r_a}, {8'h01, 8'h3C});

        // Table-driven ALU vectors through the scoreboard
        for (int i = 0; i < 15; i++) begin
            strobe(c_LOAD_A, vecs[i].a);
            strobe(c_LOAD_B, vecs[i].b);
            exp_q.push_back({vecs[i].y, vecs[i].f});
            strobe(c_START, {4'b0000, vecs[i].sh, vecs[i].op});
            check_result($sformatf("vec%0d", i), 1'b1);
        end

        // Outputs hold through a load; done drops
        strobe(c_LOAD_A, 8'h77);
        chk("hold after load", {uo_out, uio_out}, {8'hA5, 4'b0010, 1'b0, 3'b000});

        // Subtract, then shift on the retained B with a reloaded A
        strobe(c_LOAD_A, 8'h05);
        strobe(c_LOAD_B, 8'h05);
        exp_q.push_back({8'h00, 4'b1100});
        strobe(c_START, 8'h04);
        check_result("retain sub", 1'b1);
        strobe(c_LOAD_A, 8'h81);
        exp_q.push_back({8'hC0, 4'b1010});
        strobe(c_START, 8'h0B);
        check_result("retain asr", 1'b1);

        // CLEAR wipes the held result
        strobe(c_CLEAR, 8'h00);
        chk("clear outputs", {uo_out, uio_out}, 16'h0000);

        // Missing operand
        do_reset();
        strobe(c_LOAD_A, 8'h10);
        strobe(c_START, 8'h00);
        chk("missing op state", {14'd0, dut.r_state}, 16'h0000);
        chk("missing op err", {15'd0, dut.r_err}, 16'h0001);
        chk("missing op outputs", {uo_out, uio_out}, 16'h0000);
        strobe(c_CLEAR, 8'h00);
        chk("clear err", {15'd0, dut.r_err}, 16'h0000);

        // Busy collision: a pulse forced into the EXEC cycle is dropped
        do_reset();
        strobe(c_LOAD_A, 8'h10);
        strobe(c_LOAD_B, 8'h20);
        exp_q.push_back({8'h30, 4'b0000});
        fork
            strobe(c_START, 8'h00);
            begin
                wait_exec("collision", ok);
                if (ok) begin
                    force dut.w_stb = 1'b1;
                    @(negedge clk);
                    release dut.w_stb;
                end
            end
        join
        check_result("collision", 1'b0);
        chk("collision err", {15'd0, dut.r_err}, 16'h0001);

        // Asynchronous reset during EXEC
        do_reset();
        strobe(c_LOAD_A, 8'h7F);
        strobe(c_LOAD_B, 8'h01);
        exp_q.push_back({8'h80, 4'b0011});
        strobe(c_START, 8'h00);
        check_result("pre-reset add", 1'b1);
        fork
            strobe(c_START, 8'h00);
            begin
                wait_exec("reset mid-exec", ok);
                if (ok) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk("async rst uo_out", {8'd0, uo_out}, 16'h0000);
                    chk("async rst uio_out", {8'd0, uio_out}, 16'h0000);
                end
            end
        join
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post rst outputs", {uo_out, uio_out}, 16'h0000);
        chk("post rst state", {14'd0, dut.r_state}, 16'h0000);

        // ena low blocks strobes
        ena = 1'b0;
        strobe(c_LOAD_A, 8'hFF);
        chk("ena low a_vld", {15'd0, dut.r_a_vld}, 16'h0000);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        chk("ena restore a_vld", {15'd0, dut.r_a_vld}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
